// File: rtl/parity_stream_gen.sv
// parity_stream_gen
//
// Streaming parity generator with a single registered output stage.
// For every accepted input word it produces:
//   - the word parity under the frame's parity mode (even/odd),
//   - an optional check of a received parity bit against the computed one,
//   - on the final beat of a frame, the frame-level parity and the beat count.
// It also keeps a saturating count of beats whose received parity was wrong.
//
// Parameters:
//   DATA_W  data word width in bits (>= 1)
//   LEN_W   width of the saturating frame beat counter
//   ERR_W   width of the saturating parity-error counter
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   mode           0 = even parity, 1 = odd parity; taken from the first beat of a frame
//   chk_en         compare in_par against the computed word parity
//   err_clr        synchronous clear of err_cnt
//   in_valid       input beat valid
//   in_ready       input beat accepted when in_valid & in_ready
//   in_data        input word
//   in_par         received parity bit (only used when chk_en = 1)
//   in_last        final beat of frame
//   out_valid      output beat valid
//   out_ready      downstream accept
//   out_data       registered copy of in_data
//   out_par        parity bit of out_data under the frame's mode
//   out_last       registered in_last
//   out_err        received parity bit disagreed with the computed one
//   out_frame_par  frame parity, non-zero only on the last beat
//   out_frame_len  beats in frame including the last, non-zero only on the last beat
//   err_cnt        running count of accepted beats flagged with out_err

module parity_stream_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              chk_en,
    input  logic              err_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par,
    output logic              out_last,
    output logic              out_err,
    output logic              out_frame_par,
    output logic [LEN_W-1:0]  out_frame_len,
    output logic [ERR_W-1:0]  err_cnt
);

    // Output register stage
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_par_q, out_par_d;
    logic              out_last_q, out_last_d;
    logic              out_err_q, out_err_d;
    logic              out_frame_par_q, out_frame_par_d;
    logic [LEN_W-1:0]  out_frame_len_q, out_frame_len_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    // Frame tracking state
    logic              in_frame_q, in_frame_d;
    logic              frame_mode_q, frame_mode_d;
    logic              acc_q, acc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    // Per-beat combinational terms
    logic              accept;
    logic              first_beat;
    logic              eff_mode;
    logic              data_par;
    logic              word_par;
    logic              acc_next;
    logic [LEN_W-1:0]  cnt_next;
    logic              beat_err;

    // The output register can take a new beat when it is empty or being drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        first_beat = !in_frame_q;
        // The mode input only matters on the first beat; later beats reuse the latched mode.
        eff_mode   = first_beat ? mode : frame_mode_q;
        data_par   = ^in_data;
        word_par   = data_par ^ eff_mode;
        // Accumulator restarts on the first beat so a dropped frame leaves no residue.
        acc_next   = (first_beat ? 1'b0 : acc_q) ^ data_par;
        if (first_beat) begin
            cnt_next = LEN_W'(1);
        end else if (cnt_q == {LEN_W{1'b1}}) begin
            cnt_next = cnt_q;
        end else begin
            cnt_next = cnt_q + LEN_W'(1);
        end
        beat_err   = chk_en && (in_par != word_par);
    end

    // Output stage and frame state next-state logic
    always_comb begin
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_par_d       = out_par_q;
        out_last_d      = out_last_q;
        out_err_d       = out_err_q;
        out_frame_par_d = out_frame_par_q;
        out_frame_len_d = out_frame_len_q;
        in_frame_d      = in_frame_q;
        frame_mode_d    = frame_mode_q;
        acc_d           = acc_q;
        cnt_d           = cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_par_d   = word_par;
            out_last_d  = in_last;
            out_err_d   = beat_err;
            if (first_beat) begin
                frame_mode_d = mode;
            end
            if (in_last) begin
                out_frame_par_d = acc_next ^ eff_mode;
                out_frame_len_d = cnt_next;
                in_frame_d      = 1'b0;
                acc_d           = 1'b0;
                cnt_d           = '0;
            end else begin
                out_frame_par_d = 1'b0;
                out_frame_len_d = '0;
                in_frame_d      = 1'b1;
                acc_d           = acc_next;
                cnt_d           = cnt_next;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Error counter: counts accepted error beats, independent of output handshakes.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            // A clear coinciding with an error beat leaves that beat counted.
            err_cnt_d = (accept && beat_err) ? ERR_W'(1) : '0;
        end else if (accept && beat_err && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_par_q       <= 1'b0;
            out_last_q      <= 1'b0;
            out_err_q       <= 1'b0;
            out_frame_par_q <= 1'b0;
            out_frame_len_q <= '0;
            err_cnt_q       <= '0;
            in_frame_q      <= 1'b0;
            frame_mode_q    <= 1'b0;
            acc_q           <= 1'b0;
            cnt_q           <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_par_q       <= out_par_d;
            out_last_q      <= out_last_d;
            out_err_q       <= out_err_d;
            out_frame_par_q <= out_frame_par_d;
            out_frame_len_q <= out_frame_len_d;
            err_cnt_q       <= err_cnt_d;
            in_frame_q      <= in_frame_d;
            frame_mode_q    <= frame_mode_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_par       = out_par_q;
    assign out_last      = out_last_q;
    assign out_err       = out_err_q;
    assign out_frame_par = out_frame_par_q;
    assign out_frame_len = out_frame_len_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: doc/parity_stream_gen.md
Name: parity_stream_gen

Overview:
- Streaming, parametrised successor to the combinational 4-bit parity generator.
- Computes per-word parity for DATA_W-bit words under a valid/ready handshake, accumulates frame-level parity and beat count across in_last-delimited frames, and optionally checks a supplied parity bit, counting mismatches.
- Sits between a packet source and a serial/link framer that appends parity bits.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- LEN_W, 16, width of frame beat counter (saturating).
- ERR_W, 8, width of parity-error counter (saturating).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = even parity, 1 = odd parity; sampled on first beat of each frame.
- chk_en  in  1  1 = compare in_par against computed word parity.
- err_clr  in  1  synchronous clear of err_cnt.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DATA_W  input word.
- in_par  in  1  received parity bit (used only when chk_en=1).
- in_last  in  1  final beat of frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  registered copy of in_data.
- out_par  out  1  parity bit of out_data under the frame's mode.
- out_last  out  1  registered in_last.
- out_err  out  1  1 = chk_en was set and in_par != computed parity for this beat.
- out_frame_par  out  1  frame parity; meaningful only when out_last=1, else 0.
- out_frame_len  out  LEN_W  beats in frame including last; meaningful only when out_last=1, else 0.
- err_cnt  out  ERR_W  running count of out_err beats.

Behaviour:
- Reset (rst_n=0, immediate): out_valid=0, out_data=0, out_par=0, out_last=0, out_err=0, out_frame_par=0, out_frame_len=0, err_cnt=0; internal in_frame=0, frame_mode=0, frame accumulator=0, beat counter=0.
- Handshake: single output register stage. in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready. On accept, the output register loads next cycle with out_valid=1: latency 1 cycle, full throughput. No accept while out_valid & !out_ready: all out_* stay stable. out_valid clears when out_ready is high and there is no accept in the same cycle.
- Mode latch: on accepted beat with in_frame=0, frame_mode <= mode and in_frame <= 1. Eff_mode = mode on that first beat, frame_mode afterwards. Mid-frame mode changes are ignored. in_frame <= 0 on accepted in_last.
- Word parity: out_par = (^in_data) ^ eff_mode, so total ones including the parity bit is even for mode 0 and odd for mode 1.
- Frame accumulator: acc_next = (first beat ? 0 : acc) ^ (^in_data). On accepted last beat: out_frame_par = acc_next ^ eff_mode, out_frame_len = beat count including this beat. acc and count then reset to 0. Count saturates at 2^LEN_W-1.
- Single-beat frame (in_last on first beat): frame_par equals that word's out_par, frame_len=1.
- Check: out_err = chk_en & (in_par != computed out_par), registered with the beat. When chk_en=0, out_err=0.
- err_cnt increments by 1 on each accepted beat with error, saturating at 2^ERR_W-1. If err_clr is asserted in the same cycle as an error beat, err_cnt <= 1. err_clr alone gives 0.
- err_cnt counts accepted beats, not output handshakes.
- Reset asserted mid-frame drops the partial frame. The next accepted beat starts a new frame.

Test Plan:
- DATA_W=8, mode=0, single-beat frame 0xA5 -> out_par=0, out_frame_par=0, out_frame_len=1. Same with mode=1 -> out_par=1, out_frame_par=1.
- Mode=0 frame 0x01,0x03,0x07(last), back-to-back -> out_par 1,0,1. Last beat: out_frame_par=0 (6 ones), out_frame_len=3. out_valid continuous, 1-cycle latency.
- Mode=0 on beat 1 and mode=1 on beats 2-3 of a 3-beat frame -> all out_par and out_frame_par computed as even. The next frame, with mode=1 on its first beat, uses odd.
- Backpressure: out_ready=0 for 3 cycles while holding 0x3C -> in_ready=0, out_data stays 0x3C. Release -> exactly one transfer, no duplication or loss.
- chk_en=1, mode=0, 0x01 with in_par=0 -> out_err=1, err_cnt=1. With in_par=1 -> out_err=0. ERR_W=2: five error beats -> err_cnt=3. err_clr coincident with an error beat -> err_cnt=1.
- Reset pulsed after beat 2 of a 4-beat frame -> all outputs 0 immediately. A following 2-beat frame reports out_frame_len=2 and parity of those 2 beats only.
